// File: rtl/regfile_sb_if.sv
// Bus bundle between the issue/writeback stages and the regfile_sb register file.
// Selectors use 0=NONE, 1..8=r0..r7; 9..15 are invalid.
interface regfile_sb_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       rd_a_sel;
  logic [WIDTH-1:0] rd_a_data;
  logic             rd_a_ready;
  logic [3:0]       rd_b_sel;
  logic [WIDTH-1:0] rd_b_data;
  logic             rd_b_ready;
  logic             wr_en;
  logic [3:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             issue_en;
  logic [3:0]       issue_sel;
  logic [7:0]       busy;
  logic             sel_err;

  modport master (
    output rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, issue_en, issue_sel,
    input  rd_a_data, rd_a_ready, rd_b_data, rd_b_ready, busy, sel_err
  );

  modport slave (
    input  rd_a_sel, rd_b_sel, wr_en, wr_sel, wr_data, issue_en, issue_sel,
    output rd_a_data, rd_a_ready, rd_b_data, rd_b_ready, busy, sel_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Eight-entry register file with a busy scoreboard: two bypassed read ports,
// one writeback port, and an issue port that marks destinations pending.
module regfile_sb #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  logic [WIDTH-1:0] regs [8];
  logic [7:0]       busy_q;
  logic             sel_err_q;

  function automatic logic sel_valid(input logic [3:0] s);
    return (s >= 4'd1) && (s <= 4'd8);
  endfunction

  function automatic logic [2:0] sel_idx(input logic [3:0] s);
    logic [3:0] t;
    t = s - 4'd1;
    return t[2:0];
  endfunction

  logic       wr_hit;
  logic [2:0] wr_idx;
  logic       issue_hit;
  logic [2:0] issue_idx;

  assign wr_hit    = bus.wr_en && sel_valid(bus.wr_sel);
  assign wr_idx    = sel_idx(bus.wr_sel);
  assign issue_hit = bus.issue_en && sel_valid(bus.issue_sel);
  assign issue_idx = sel_idx(bus.issue_sel);

  // Read port A; a same-cycle writeback both bypasses data and clears the hazard.
  always_comb begin
    bus.rd_a_data  = '0;
    bus.rd_a_ready = 1'b1;
    if (sel_valid(bus.rd_a_sel)) begin
      if (wr_hit && (bus.wr_sel == bus.rd_a_sel)) begin
        bus.rd_a_data  = bus.wr_data;
        bus.rd_a_ready = 1'b1;
      end else begin
        bus.rd_a_data  = regs[sel_idx(bus.rd_a_sel)];
        bus.rd_a_ready = !busy_q[sel_idx(bus.rd_a_sel)];
      end
    end
  end

  always_comb begin
    bus.rd_b_data  = '0;
    bus.rd_b_ready = 1'b1;
    if (sel_valid(bus.rd_b_sel)) begin
      if (wr_hit && (bus.wr_sel == bus.rd_b_sel)) begin
        bus.rd_b_data  = bus.wr_data;
        bus.rd_b_ready = 1'b1;
      end else begin
        bus.rd_b_data  = regs[sel_idx(bus.rd_b_sel)];
        bus.rd_b_ready = !busy_q[sel_idx(bus.rd_b_sel)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_idx] <= bus.wr_data;
    end
  end

  // Issue takes priority over a same-cycle writeback so the new op stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (issue_hit && (issue_idx == 3'(i)))
          busy_q[i] <= 1'b1;
        else if (wr_hit && (wr_idx == 3'(i)))
          busy_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      sel_err_q <= 1'b0;
    else if ((bus.rd_a_sel >= 4'd9) || (bus.rd_b_sel >= 4'd9) ||
             (bus.wr_en && (bus.wr_sel >= 4'd9)) ||
             (bus.issue_en && (bus.issue_sel >= 4'd9)))
      sel_err_q <= 1'b1;
  end

  assign bus.busy    = busy_q;
  assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb: inputs driven on the falling edge,
// outputs compared 1 ns later, state advances on the following rising edge.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(8)) bus ();

  regfile_sb #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       rst;
    logic [3:0] a_sel;
    logic [3:0] b_sel;
    logic       wr_en;
    logic [3:0] wr_sel;
    logic [7:0] wr_data;
    logic       issue_en;
    logic [3:0] issue_sel;
    logic [7:0] ea_data;
    logic       ea_ready;
    logic [7:0] eb_data;
    logic       eb_ready;
    logic [7:0] e_busy;
    logic       e_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] a, input logic [3:0] b,
    input logic we, input logic [3:0] ws, input logic [7:0] wd,
    input logic ie, input logic [3:0] is,
    input logic [7:0] ead, input logic ear, input logic [7:0] ebd, input logic ebr,
    input logic [7:0] eb, input logic ee);
    vec_t v;
    v.rst = r; v.a_sel = a; v.b_sel = b; v.wr_en = we; v.wr_sel = ws; v.wr_data = wd;
    v.issue_en = ie; v.issue_sel = is; v.ea_data = ead; v.ea_ready = ear;
    v.eb_data = ebd; v.eb_ready = ebr; v.e_busy = eb; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.rd_a_sel  = v.a_sel;
    bus.rd_b_sel  = v.b_sel;
    bus.wr_en     = v.wr_en;
    bus.wr_sel    = v.wr_sel;
    bus.wr_data   = v.wr_data;
    bus.issue_en  = v.issue_en;
    bus.issue_sel = v.issue_sel;
  endtask

  task automatic check(input vec_t v, input int idx);
    chk("a_data",  idx, bus.rd_a_data, v.ea_data);
    chk("a_ready", idx, {7'd0, bus.rd_a_ready}, {7'd0, v.ea_ready});
    chk("b_data",  idx, bus.rd_b_data, v.eb_data);
    chk("b_ready", idx, {7'd0, bus.rd_b_ready}, {7'd0, v.eb_ready});
    chk("busy",    idx, bus.busy, v.e_busy);
    chk("sel_err", idx, {7'd0, bus.sel_err}, {7'd0, v.e_err});
  endtask

  initial begin
    vec_t idle;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

    //     rst a   b   we ws  wd     ie is   ead    ear ebd    ebr busy   err
    vq.push_back(mk(0, 1,  8,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 0));
    vq.push_back(mk(0, 4,  5,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 0));
    vq.push_back(mk(0, 4,  0,  1, 4, 8'hA5, 0, 0,  8'hA5, 1, 8'h00, 1, 8'h00, 0));
    vq.push_back(mk(0, 0,  4,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'hA5, 1, 8'h00, 0));
    vq.push_back(mk(0, 6,  6,  0, 0, 8'h00, 1, 6,  8'h00, 1, 8'h00, 1, 8'h00, 0));
    vq.push_back(mk(0, 6,  4,  0, 0, 8'h00, 0, 0,  8'h00, 0, 8'hA5, 1, 8'h20, 0));
    vq.push_back(mk(0, 6,  0,  0, 0, 8'h00, 0, 0,  8'h00, 0, 8'h00, 1, 8'h20, 0));
    vq.push_back(mk(0, 6,  0,  0, 0, 8'h00, 0, 0,  8'h00, 0, 8'h00, 1, 8'h20, 0));
    vq.push_back(mk(0, 6,  6,  1, 6, 8'h3C, 0, 0,  8'h3C, 1, 8'h3C, 1, 8'h20, 0));
    vq.push_back(mk(0, 6,  0,  0, 0, 8'h00, 0, 0,  8'h3C, 1, 8'h00, 1, 8'h00, 0));
    vq.push_back(mk(0, 3,  3,  1, 3, 8'h11, 1, 3,  8'h11, 1, 8'h11, 1, 8'h00, 0));
    vq.push_back(mk(0, 3,  0,  0, 0, 8'h00, 0, 0,  8'h11, 0, 8'h00, 1, 8'h04, 0));
    vq.push_back(mk(0, 0,  12, 0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h04, 0));
    vq.push_back(mk(0, 0,  0,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h04, 1));
    vq.push_back(mk(0, 4,  6,  1, 15, 8'hFF, 0, 0, 8'hA5, 1, 8'h3C, 1, 8'h04, 1));
    vq.push_back(mk(0, 4,  6,  0, 0, 8'h00, 0, 0,  8'hA5, 1, 8'h3C, 1, 8'h04, 1));
    vq.push_back(mk(0, 1,  8,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h04, 1));
    // fill the scoreboard, r7=77 written while being reissued
    vq.push_back(mk(0, 8,  3,  1, 8, 8'h77, 1, 8,  8'h77, 1, 8'h11, 0, 8'h04, 1));
    vq.push_back(mk(0, 8,  0,  0, 0, 8'h00, 1, 1,  8'h77, 0, 8'h00, 1, 8'h84, 1));
    vq.push_back(mk(0, 0,  0,  0, 0, 8'h00, 1, 2,  8'h00, 1, 8'h00, 1, 8'h85, 1));
    vq.push_back(mk(0, 0,  0,  0, 0, 8'h00, 1, 4,  8'h00, 1, 8'h00, 1, 8'h87, 1));
    vq.push_back(mk(0, 0,  0,  0, 0, 8'h00, 1, 5,  8'h00, 1, 8'h00, 1, 8'h8F, 1));
    vq.push_back(mk(0, 0,  0,  0, 0, 8'h00, 1, 6,  8'h00, 1, 8'h00, 1, 8'h9F, 1));
    vq.push_back(mk(0, 0,  0,  0, 0, 8'h00, 1, 7,  8'h00, 1, 8'h00, 1, 8'hBF, 1));
    vq.push_back(mk(0, 8,  3,  0, 0, 8'h00, 0, 0,  8'h77, 0, 8'h11, 0, 8'hFF, 1));
    // reset beats a same-cycle write and issue
    vq.push_back(mk(1, 8,  1,  1, 8, 8'h99, 1, 1,  8'h99, 1, 8'h00, 0, 8'hFF, 1));
    vq.push_back(mk(0, 8,  4,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 0));
    // each sel_err source on its own
    vq.push_back(mk(0, 9,  0,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 0));
    vq.push_back(mk(0, 0,  0,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 1));
    vq.push_back(mk(1, 0,  0,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 1));
    vq.push_back(mk(0, 0,  0,  1, 9, 8'h55, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 0));
    vq.push_back(mk(0, 1,  0,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 1));
    vq.push_back(mk(1, 0,  0,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 1));
    vq.push_back(mk(0, 0,  0,  0, 0, 8'h00, 1, 13, 8'h00, 1, 8'h00, 1, 8'h00, 0));
    vq.push_back(mk(0, 0,  0,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 1));
    vq.push_back(mk(1, 0,  0,  0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 1));
    vq.push_back(mk(0, 0,  0,  0, 15, 8'h00, 0, 14, 8'h00, 1, 8'h00, 1, 8'h00, 0));
    vq.push_back(mk(0, 0,  15, 0, 0, 8'h00, 0, 0,  8'h00, 1, 8'h00, 1, 8'h00, 0));

    drive(idle);
    @(posedge clk);
    @(posedge clk);

    // after reset every register reads 0 and ready on both ports
    for (int s = 1; s <= 8; s++) begin
      vec_t v;
      @(negedge clk);
      v = mk(0, 4'(s), 4'(9 - s), 0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 1, 8'h00, 0);
      drive(v);
      #1;
      check(v, 100 + s);
    end

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check(vq[i], i);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
